// File: rtl/store_align_unit.sv
// Store path: aligns a 32-bit register value into byte lanes of a word-addressed
// memory write, with byte enables, a req/ack handshake and a bounded wait.
module store_align_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        st_done,
  output logic        st_err,
  output logic [1:0]  err_cause
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  wait_cnt_reg;
  logic        mem_req_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [3:0]  mem_be_reg;
  logic        st_done_reg;
  logic        st_err_reg;
  logic [1:0]  err_cause_reg;

  logic [7:0]  lane_byte [4];
  logic [31:0] wdata_next;
  logic [3:0]  be_next;
  logic        illegal_size;
  logic        misaligned;

  // Each lane picks its byte: bytes replicate everywhere, halves pair up, words pass through.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = (st_size == 2'b00) ? st_data[7:0] :
                             (st_size == 2'b01) ? st_data[8*(gi%2) +: 8] :
                                                  st_data[8*gi +: 8];
    end
  endgenerate

  assign wdata_next = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};

  always_comb begin
    be_next = 4'b0000;
    case (st_size)
      2'b00:   be_next = 4'b0001 << st_addr[1:0];
      2'b01:   be_next = st_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   be_next = 4'b1111;
      default: be_next = 4'b0000;
    endcase
  end

  assign illegal_size = (st_size == 2'b11);
  assign misaligned   = ((st_size == 2'b01) && st_addr[0]) ||
                        ((st_size == 2'b10) && (st_addr[1:0] != 2'b00));

  assign st_ready  = (state_reg == IDLE) && !reset;
  assign mem_req   = mem_req_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;
  assign st_done   = st_done_reg;
  assign st_err    = st_err_reg;
  assign err_cause = err_cause_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 8'd0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      mem_be_reg    <= 4'b0000;
      st_done_reg   <= 1'b0;
      st_err_reg    <= 1'b0;
      err_cause_reg <= 2'b00;
    end else begin
      st_done_reg   <= 1'b0;
      st_err_reg    <= 1'b0;
      err_cause_reg <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (st_valid) begin
            if (illegal_size || misaligned) begin
              // Rejected stores skip memory entirely; illegal size outranks misalignment.
              state_reg     <= RESP;
              st_err_reg    <= 1'b1;
              err_cause_reg <= illegal_size ? 2'b10 : 2'b01;
            end else begin
              state_reg     <= REQ;
              wait_cnt_reg  <= 8'd0;
              mem_req_reg   <= 1'b1;
              mem_addr_reg  <= {st_addr[31:2], 2'b00};
              mem_wdata_reg <= wdata_next;
              mem_be_reg    <= be_next;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_reg   <= RESP;
            mem_req_reg <= 1'b0;
            mem_be_reg  <= 4'b0000;
            st_done_reg <= 1'b1;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_reg     <= RESP;
            mem_req_reg   <= 1'b0;
            mem_be_reg    <= 4'b0000;
            st_err_reg    <= 1'b1;
            err_cause_reg <= 2'b11;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/store_align_unit.md
# store_align_unit

Data-side store path for the processor: accepts one store request (sb/sh/sw) from the execute stage, checks alignment, replicates the source register into the correct byte lanes, and drives a word-addressed data-memory write with byte enables and a request/acknowledge handshake. It is the write-direction counterpart of the immediate/load widening logic. Where that logic widens 8/16-bit quantities to 32 bits, this unit narrows 32-bit register values into 8/16-bit memory lanes. It also reports misalignment, illegal size and memory timeout back to the control unit.

## Interface

Parameters:
- `TIMEOUT`, default 16: maximum number of cycles `mem_req` may stay high without `mem_ack` before the store is aborted. Legal range 2–255.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `st_valid`, input, 1: a store request is present.
- `st_ready`, output, 1: the unit can accept a request.
- `st_size`, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
- `st_addr`, input, 32: byte address.
- `st_data`, input, 32: source register value (rt).
- `mem_req`, output, 1: memory write request.
- `mem_addr`, output, 32: word-aligned address, `{st_addr[31:2], 2'b00}`.
- `mem_wdata`, output, 32: lane-replicated write data.
- `mem_be`, output, 4: byte enables. Bit i covers `mem_wdata[8i+7:8i]`.
- `mem_ack`, input, 1: memory has written the word.
- `st_done`, output, 1: one-cycle pulse on successful completion.
- `st_err`, output, 1: one-cycle pulse on failure.
- `err_cause`, output, 2: 01 misaligned, 10 illegal size, 11 timeout. Valid only while `st_err` is high, otherwise 00.

## Operation

- States: IDLE, REQ, RESP.
  - IDLE: `st_ready` = 1.
  - REQ: `mem_req` = 1.
  - RESP: exactly one cycle; drives the `st_done` or `st_err` pulse.
- Accept: the request is taken when `st_valid & st_ready` at a rising edge. The address, size and data are registered at that edge.
- Lane formatting is little-endian, using `a = st_addr[1:0]`:
  - Byte: `mem_wdata = {4{st_data[7:0]}}`, `mem_be = 4'b0001 << a`. Any `a` is legal.
  - Half: `mem_wdata = {2{st_data[15:0]}}`, `mem_be = a[1] ? 4'b1100 : 4'b0011`. Requires `a[0] = 0`.
  - Word: `mem_wdata = st_data`, `mem_be = 4'b1111`. Requires `a = 00`.
- Legal request: IDLE → REQ.
- Misaligned or illegal-size request: IDLE → RESP with the error latched. `mem_req` is never asserted and no memory write occurs.
- In REQ, `mem_req`, `mem_addr`, `mem_wdata` and `mem_be` are held stable until the handshake ends.
- `mem_ack` while in REQ: → RESP with success.
- Wait counter:
  - 8 bits, cleared on entry to REQ, increments each REQ cycle in which `mem_ack` = 0.
  - When it reaches `TIMEOUT-1` without ack: → RESP, `err_cause` = 11, `mem_req` drops.
  - Ack in that same cycle wins: the store completes successfully.
- RESP → IDLE unconditionally.
- `mem_ack` outside REQ is ignored.
- When `mem_req` = 0, `mem_be` = 0. `mem_addr` and `mem_wdata` keep their last values.

## Timing

- Reset values: state IDLE, `mem_req` 0, `mem_be` 0, `mem_addr` 0, `mem_wdata` 0, `st_done` 0, `st_err` 0, `err_cause` 00, counter 0.
- While `reset` is high, `st_ready` is forced to 0. It is 1 in the first cycle after `reset` falls.
- Reset mid-operation (in REQ or RESP):
  - Next cycle: `mem_req` = 0 and the unit is in IDLE.
  - No `st_done` or `st_err` pulse is produced for the aborted store.
- Successful store, with acceptance at edge 0:
  - `mem_req` is high from cycle 1.
  - If ack arrives in cycle k ≥ 1, `mem_req` falls and `st_done` = 1 in cycle k+1.
  - `st_ready` = 1 in cycle k+2.
  - Minimum issue interval is 3 cycles per store.
- Error store: `st_err` = 1 in cycle 1, `st_ready` = 1 in cycle 2.
- Timeout: with `mem_req` first high in cycle 1 and no ack, `mem_req` is high for exactly `TIMEOUT` cycles. `st_err` (cause 11) is asserted in cycle `TIMEOUT+1`.
- `st_ready` is combinational from state and reset only. It never depends on `st_valid`.

## Test plan

- Byte stores: `st_data` = 0xA1B2C3D4, addr 0x103, size 00 → `mem_addr` 0x100, `mem_wdata` 0xD4D4D4D4, `mem_be` 0b1000. Ack in cycle 1 gives `st_done` in cycle 2. Repeat for addr 0x100–0x102 and check be 0001/0010/0100.
- Half store: addr 0x206, data 0x12345678 → `mem_be` 0b1100, `mem_wdata` 0x56785678. Same request with addr 0x205 → `st_err` in cycle 1, `err_cause` 01, `mem_req` never high.
- Word and illegal size:
  - Word at 0x300 with ack delayed 5 cycles → `mem_req` held for 5 cycles with stable `mem_wdata`; `st_done` one cycle after ack.
  - Word at 0x302 → cause 01.
  - size 11 → cause 10.
- Timeout with `TIMEOUT` = 4, no ack → `mem_req` high in cycles 1–4, `st_err`/cause 11 in cycle 5. A second run asserts ack in cycle 4 → `st_done` with no error.
- Reset in the second REQ cycle → `mem_req` 0 and `st_ready` 1 after reset release, no done/err pulse. A stray `mem_ack` in IDLE → no response.
- Back-to-back: `st_valid` held high with four stores and zero-wait ack → acceptances every 3 cycles, four `st_done` pulses in order, lanes correct for each.
